// File: rtl/ctrl_pkg.sv
// WISC-S16 decode definitions: opcodes, ALU encodings, control-word bit layout,
// FSM states and the combinational decode table used by ctrl_decode_pipe.
package ctrl_pkg;

  localparam int CTRL_LAYOUT_W = 24;
  localparam int EXC_CNT_W     = 4;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_RTI   = 5'b00011;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHR   = 5'b11010;
  localparam logic [4:0] OP_ARI   = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;

  localparam logic [2:0] ALU_ROL = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_ROR = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  // Control word layout, MSB first: aluop[23:21] then single-bit flags down to halt.
  localparam int C_ALUOP    = 21;
  localparam int C_ALUSRC   = 20;
  localparam int C_BRANCH   = 19;
  localparam int C_JUMP     = 18;
  localparam int C_JUMPREG  = 17;
  localparam int C_SET      = 16;
  localparam int C_BTR      = 15;
  localparam int C_REGWRITE = 14;
  localparam int C_MEMWRITE = 13;
  localparam int C_MEMREAD  = 12;
  localparam int C_MEMTOREG = 11;
  localparam int C_INVA     = 10;
  localparam int C_INVB     = 9;
  localparam int C_CIN      = 8;
  localparam int C_ZEROEXT  = 7;
  localparam int C_SLBI     = 6;
  localparam int C_LINK     = 5;
  localparam int C_LBI      = 4;
  localparam int C_STU      = 3;
  localparam int C_RTI      = 2;
  localparam int C_EXCP     = 1;
  localparam int C_HALT     = 0;

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_EXC} state_t;

  typedef enum logic [1:0] {RD_R, RD_I1, RD_I2, RD_R7} rd_sel_t;

  typedef struct packed {
    logic [CTRL_LAYOUT_W-1:0] ctrl;
    logic                     use_rs;
    logic                     use_rt;
    rd_sel_t                  rd_sel;
  } decode_t;

  function automatic decode_t decode(input logic [4:0] op, input logic [1:0] fn);
    decode_t d;
    d = '0;
    d.rd_sel = RD_R;
    case (op)
      OP_HALT: d.ctrl[C_HALT] = 1'b1;
      OP_NOP:  d.ctrl = '0;
      OP_SIIC: d.ctrl[C_EXCP] = 1'b1;
      OP_RTI:  d.ctrl[C_RTI] = 1'b1;
      OP_J:    d.ctrl[C_JUMP] = 1'b1;
      OP_JR: begin
        d.ctrl[C_JUMP] = 1'b1;
        d.ctrl[C_JUMPREG] = 1'b1;
        d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        d.ctrl[C_ALUSRC] = 1'b1;
        d.use_rs = 1'b1;
      end
      OP_JAL: begin
        d.ctrl[C_JUMP] = 1'b1;
        d.ctrl[C_LINK] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.rd_sel = RD_R7;
      end
      OP_JALR: begin
        d.ctrl[C_JUMP] = 1'b1;
        d.ctrl[C_JUMPREG] = 1'b1;
        d.ctrl[C_LINK] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        d.ctrl[C_ALUSRC] = 1'b1;
        d.use_rs = 1'b1;
        d.rd_sel = RD_R7;
      end
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
        d.ctrl[C_ALUSRC] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.rd_sel = RD_I1;
        case (op[1:0])
          2'b00: d.ctrl[C_ALUOP +: 3] = ALU_ADD;
          2'b01: begin
            // SUBI computes imm - rs
            d.ctrl[C_ALUOP +: 3] = ALU_ADD;
            d.ctrl[C_INVA] = 1'b1;
            d.ctrl[C_CIN] = 1'b1;
          end
          2'b10: begin
            d.ctrl[C_ALUOP +: 3] = ALU_XOR;
            d.ctrl[C_ZEROEXT] = 1'b1;
          end
          default: begin
            d.ctrl[C_ALUOP +: 3] = ALU_AND;
            d.ctrl[C_INVB] = 1'b1;
            d.ctrl[C_ZEROEXT] = 1'b1;
          end
        endcase
      end
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
        d.ctrl[C_BRANCH] = 1'b1;
        d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        d.use_rs = 1'b1;
      end
      OP_ST: begin
        d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        d.ctrl[C_ALUSRC] = 1'b1;
        d.ctrl[C_MEMWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.rd_sel = RD_I1;
      end
      OP_LD: begin
        d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        d.ctrl[C_ALUSRC] = 1'b1;
        d.ctrl[C_MEMREAD] = 1'b1;
        d.ctrl[C_MEMTOREG] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.rd_sel = RD_I1;
      end
      OP_SLBI: begin
        d.ctrl[C_ALUOP +: 3] = ALU_OR;
        d.ctrl[C_ALUSRC] = 1'b1;
        d.ctrl[C_SLBI] = 1'b1;
        d.ctrl[C_ZEROEXT] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.rd_sel = RD_I2;
      end
      OP_STU: begin
        d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        d.ctrl[C_ALUSRC] = 1'b1;
        d.ctrl[C_MEMWRITE] = 1'b1;
        d.ctrl[C_STU] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.rd_sel = RD_I2;
      end
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        d.ctrl[C_ALUOP +: 3] = {1'b0, op[1:0]};
        d.ctrl[C_ALUSRC] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.rd_sel = RD_I1;
      end
      OP_LBI: begin
        d.ctrl[C_LBI] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.rd_sel = RD_I2;
      end
      OP_BTR: begin
        d.ctrl[C_BTR] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
      end
      OP_SHR: begin
        d.ctrl[C_ALUOP +: 3] = {1'b0, fn};
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      OP_ARI: begin
        d.ctrl[C_REGWRITE] = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        case (fn)
          FN_ADD: d.ctrl[C_ALUOP +: 3] = ALU_ADD;
          FN_SUB: begin
            d.ctrl[C_ALUOP +: 3] = ALU_ADD;
            d.ctrl[C_INVA] = 1'b1;
            d.ctrl[C_CIN] = 1'b1;
          end
          FN_XOR: d.ctrl[C_ALUOP +: 3] = ALU_XOR;
          FN_ANDN: begin
            d.ctrl[C_ALUOP +: 3] = ALU_AND;
            d.ctrl[C_INVB] = 1'b1;
          end
          default: d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        endcase
      end
      OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
        // compares evaluate rs - rt; SCO wants the raw carry of rs + rt
        d.ctrl[C_SET] = 1'b1;
        d.ctrl[C_REGWRITE] = 1'b1;
        d.ctrl[C_ALUOP +: 3] = ALU_ADD;
        d.ctrl[C_INVB] = (op != OP_SCO);
        d.ctrl[C_CIN] = (op != OP_SCO);
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      default: d.ctrl = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_load_scoreboard.sv
// Shift register of in-flight load destinations with a combinational
// source-operand match that flags load-use hazards.
module ctrl_load_scoreboard
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [REG_W-1:0] load_reg,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  output logic             hazard
);

  logic [DEPTH-1:0] vld;
  logic [REG_W-1:0] regs [DEPTH];
  logic             hit_rs;
  logic             hit_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clear) begin
      vld <= '0;
    end else if (shift) begin
      vld[0]  <= load_valid;
      regs[0] <= load_reg;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        regs[i] <= regs[i-1];
      end
    end
  end

  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (regs[i] == rs)) hit_rs = 1'b1;
      if (vld[i] && (regs[i] == rt)) hit_rt = 1'b1;
    end
    hazard = (use_rs & hit_rs) | (use_rt & hit_rt);
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered valid/ready decode stage with load-use stall and HALT/SIIC FSM.
// Optional CTRL_PERF_CNT_EN adds saturating issue/stall counters.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int HAZ_DEPTH  = 2,
  parameter int EXC_CYCLES = 3,
  parameter int REG_W      = 3,
  parameter int CTRL_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [REG_W-1:0]  rs_idx,
  output logic [REG_W-1:0]  rt_idx,
  output logic [REG_W-1:0]  rd_idx,
  output logic              halted,
  output logic              exc_busy
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_stall
`endif
);

  decode_t                dec;
  state_t                 state;
  logic [EXC_CNT_W-1:0]   exc_cnt;
  logic [REG_W-1:0]       rs_dec;
  logic [REG_W-1:0]       rt_dec;
  logic [REG_W-1:0]       rd_dec;
  logic                   adv;
  logic                   hazard;
  logic                   accept;
  logic                   flush_eff;

  assign dec    = decode(instr[15:11], instr[1:0]);
  assign rs_dec = REG_W'(instr[10:8]);
  assign rt_dec = REG_W'(instr[7:5]);

  always_comb begin
    rd_dec = REG_W'(instr[4:2]);
    case (dec.rd_sel)
      RD_I1:   rd_dec = REG_W'(instr[7:5]);
      RD_I2:   rd_dec = REG_W'(instr[10:8]);
      RD_R7:   rd_dec = '1;
      default: rd_dec = REG_W'(instr[4:2]);
    endcase
  end

  // A halted core is frozen, so flush has no effect there at all.
  assign flush_eff = flush & (state != ST_HALT);
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = rst_n & (state == ST_RUN) & adv & ~hazard & ~flush;
  assign accept    = in_valid & in_ready;

  ctrl_load_scoreboard #(
    .DEPTH (HAZ_DEPTH),
    .REG_W (REG_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift      (adv),
    .clear      (flush_eff),
    .load_valid (accept & dec.ctrl[C_MEMREAD]),
    .load_reg   (rd_dec),
    .rs         (rs_dec),
    .rt         (rt_dec),
    .use_rs     (dec.use_rs),
    .use_rt     (dec.use_rt),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      rs_idx    <= '0;
      rt_idx    <= '0;
      rd_idx    <= '0;
    end else if (flush_eff) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= accept;
      if (accept) begin
        ctrl   <= CTRL_W'(dec.ctrl);
        rs_idx <= rs_dec;
        rt_idx <= rt_dec;
        rd_idx <= rd_dec;
      end
    end
  end

  // The counter reaching zero and the return to RUN happen on the same edge,
  // so EXC lasts exactly EXC_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      exc_cnt  <= '0;
      halted   <= 1'b0;
      exc_busy <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && dec.ctrl[C_HALT]) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (accept && dec.ctrl[C_EXCP]) begin
            state    <= ST_EXC;
            exc_busy <= 1'b1;
            exc_cnt  <= EXC_CNT_W'(EXC_CYCLES);
          end
        end
        ST_EXC: begin
          if (flush || (exc_cnt <= EXC_CNT_W'(1))) begin
            state    <= ST_RUN;
            exc_busy <= 1'b0;
            exc_cnt  <= '0;
          end else begin
            exc_cnt <= exc_cnt - EXC_CNT_W'(1);
          end
        end
        ST_HALT: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          exc_busy <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && (perf_issued != 16'hFFFF)) perf_issued <= perf_issued + 16'd1;
      if (in_valid && hazard && (state == ST_RUN) && (perf_stall != 16'hFFFF))
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe (HAZ_DEPTH=1, EXC_CYCLES=3); expected words
// are queued on accept and compared when the stage delivers them.
module tb_ctrl_decode_pipe;

  // Control bit positions and expected words, derived independently of the RTL package
  localparam logic [23:0] W_LD   = (24'd4 << 21) | (24'd1 << 20) | (24'd1 << 14) | (24'd1 << 12) | (24'd1 << 11);
  localparam logic [23:0] W_ADD  = (24'd4 << 21) | (24'd1 << 14);
  localparam logic [23:0] W_SUB  = (24'd4 << 21) | (24'd1 << 14) | (24'd1 << 10) | (24'd1 << 8);
  localparam logic [23:0] W_ADDI = (24'd4 << 21) | (24'd1 << 20) | (24'd1 << 14);
  localparam logic [23:0] W_LBI  = (24'd1 << 14) | (24'd1 << 4);
  localparam logic [23:0] W_JAL  = (24'd1 << 18) | (24'd1 << 14) | (24'd1 << 5);
  localparam logic [23:0] W_ST   = (24'd4 << 21) | (24'd1 << 20) | (24'd1 << 13);
  localparam logic [23:0] W_SIIC = 24'd1 << 1;
  localparam logic [23:0] W_HALT = 24'd1;

  typedef struct {
    logic [23:0] c;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] ctrl;
  logic [2:0]  rs_idx;
  logic [2:0]  rt_idx;
  logic [2:0]  rd_idx;
  logic        halted;
  logic        exc_busy;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_del = 0;
  int   prev_del = 0;

  ctrl_decode_pipe #(
    .HAZ_DEPTH  (1),
    .EXC_CYCLES (3),
    .REG_W      (3),
    .CTRL_W     (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl      (ctrl),
    .rs_idx    (rs_idx),
    .rt_idx    (rt_idx),
    .rd_idx    (rd_idx),
    .halted    (halted),
    .exc_busy  (exc_busy)
`ifdef CTRL_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offers one instruction, waits (bounded) for in_ready and queues its expected word
  task automatic applyStimulus(input logic [15:0] ins, input logic [23:0] ec,
                               input logic [2:0] ers, input logic [2:0] ert,
                               input logic [2:0] erd, input int exp_wait, input string tag);
    int   waited;
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    instr    = ins;
    @(negedge clk);
    while (!in_ready && waited < 30) begin
      @(posedge clk); #1;
      waited++;
      @(negedge clk);
    end
    checkOutput({tag, "_wait"}, waited, exp_wait);
    if (in_ready) begin
      e.c = ec; e.rs = ers; e.rt = ert; e.rd = erd;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_ctrl", ctrl, e.c);
        checkOutput("out_rs", rs_idx, e.rs);
        checkOutput("out_rt", rt_idx, e.rt);
        checkOutput("out_rd", rd_idx, e.rd);
      end
      prev_del = last_del;
      last_del = cyc;
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    instr     = 16'h4225;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_ctrl", ctrl, 0);
    checkOutput("rst_idx", {rs_idx, rt_idx, rd_idx}, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_exc_busy", exc_busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
`ifdef CTRL_PERF_CNT_EN
    checkOutput("rst_perf", {perf_issued, perf_stall}, 0);
`endif
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] load-use stall");
    applyStimulus(16'h8A20, W_LD, 3'd2, 3'd1, 3'd1, 0, "ld1");
    applyStimulus(16'hD968, W_ADD, 3'd1, 3'd3, 3'd2, 1, "add_dep");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_gap", last_del - prev_del, 2);
`ifdef CTRL_PERF_CNT_EN
    checkOutput("perf_issued", perf_issued, 2);
    checkOutput("perf_stall", perf_stall, 1);
`endif

    $display("[TB] load then independent use");
    applyStimulus(16'h8A20, W_LD, 3'd2, 3'd1, 3'd1, 0, "ld2");
    applyStimulus(16'h4225, W_ADDI, 3'd2, 3'd1, 3'd1, 0, "addi_indep");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("nostall_gap", last_del - prev_del, 1);

    $display("[TB] backpressure hold");
    out_ready = 1'b0;
    applyStimulus(16'h4225, W_ADDI, 3'd2, 3'd1, 3'd1, 0, "addi_bp");
    in_valid = 1'b1;
    instr    = 16'hC1FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_ctrl", ctrl, W_ADDI);
      checkOutput("bp_rd", rd_idx, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(16'hC1FF, W_LBI, 3'd1, 3'd7, 3'd1, 0, "lbi");

    $display("[TB] exception window");
    applyStimulus(16'h1000, W_SIIC, 3'd0, 3'd0, 3'd0, 0, "siic");
    in_valid = 1'b1;
    instr    = 16'hD969;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("exc_busy_on", exc_busy, 1);
      checkOutput("exc_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    applyStimulus(16'hD969, W_SUB, 3'd1, 3'd3, 3'd2, 0, "sub_after_exc");
    @(negedge clk);
    checkOutput("exc_busy_off", exc_busy, 0);
    @(posedge clk); #1;

    applyStimulus(16'h3123, W_JAL, 3'd1, 3'd1, 3'd7, 0, "jal");
    applyStimulus(16'h8225, W_ST, 3'd2, 3'd1, 3'd1, 0, "st");

    $display("[TB] flush during exception");
    applyStimulus(16'h1000, W_SIIC, 3'd0, 3'd0, 3'd0, 0, "siic_fl");
    flush = 1'b1;
    @(negedge clk);
    checkOutput("exc_fl_busy", exc_busy, 1);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    applyStimulus(16'h4225, W_ADDI, 3'd2, 3'd1, 3'd1, 0, "addi_after_exc_fl");

    $display("[TB] flush with pending hazard");
    applyStimulus(16'h8A20, W_LD, 3'd2, 3'd1, 3'd1, 0, "ld3");
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 16'hD968;
    @(negedge clk);
    checkOutput("flush_in_ready", in_ready, 0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    applyStimulus(16'hD968, W_ADD, 3'd1, 3'd3, 3'd2, 0, "add_after_flush");
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] halt");
    applyStimulus(16'h0000, W_HALT, 3'd0, 3'd0, 3'd0, 0, "halt");
    in_valid = 1'b1;
    instr    = 16'h4225;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("halt_in_ready", in_ready, 0);
      checkOutput("halt_halted", halted, 1);
      if (i > 0) checkOutput("halt_out_valid", out_valid, 0);
      @(posedge clk); #1;
      flush = (i % 2 == 0);
    end
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_halted", halted, 0);
    checkOutput("rst2_out_valid", out_valid, 0);
    checkOutput("rst2_in_ready", in_ready, 0);
    checkOutput("queue_empty", exp_q.size(), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Registered, handshaked decode/control stage for the WISC-S16 pipelined core; the successor to the single-cycle combinational control decoder.
- Decodes a 16-bit instruction into a packed control word plus register indices and holds it in a valid/ready pipeline register.
- Detects load-use hazards against a parametrised scoreboard of in-flight loads and inserts bubbles.
- Sequences HALT, SIIC exception and flush via a small FSM.

Parameters:
- HAZ_DEPTH, 2: number of in-flight load destinations tracked (1..4).
- EXC_CYCLES, 3: cycles input is blocked after accepting SIIC (1..15).
- REG_W, 3: register index width.
- CTRL_W, 24: packed control word width; layout defined in ctrl_pkg.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- instr  in  16  instruction; opcode [15:11], func [1:0].
- flush  in  1  squash held entry and scoreboard (branch/jump resolve).
- out_valid  out  1  control word valid to execute.
- out_ready  in  1  execute accepts.
- ctrl  out  CTRL_W  packed control word (aluop[2:0], alusrc, branch, jump, jumpreg, set, btr, regwrite, memwrite, memread, memtoreg, invA, invB, cin, zeroext, slbi, link, lbi, stu, rti, excp, halt).
- rs_idx, rt_idx, rd_idx  out  REG_W each  source/destination indices.
- halted  out  1  core halted.
- exc_busy  out  1  in exception window.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, ctrl=0, all idx=0, scoreboard cleared, state RUN, halted=0, exc_busy=0, in_ready=0 while rst_n=0.
- Decode is combinational from instr per the WISC decode table in ctrl_pkg.
- Index fields:
  - rs=[10:8]; rt=[7:5].
  - rd=[4:2] for R-format, [7:5] for I-format-1, [10:8] for I-format-2/LBI/SLBI/STU, 7 for JAL/JALR.
  - use_rs/use_rt flags come from the table.
- Hazard: asserted when use_rs/use_rt and the corresponding index matches any valid scoreboard entry.
- Advance condition: adv = !out_valid | out_ready.
- Handshake:
  - in_ready = (state==RUN) & adv & !hazard & !flush.
  - Accept = in_valid & in_ready.
  - Latency one cycle: accepted instruction's ctrl is visible the next cycle with out_valid=1.
  - ctrl/idx hold stable while out_valid & !out_ready.
- Bubble: when adv & (hazard | state!=RUN | !in_valid), out_valid goes 0 next cycle.
- Scoreboard:
  - HAZ_DEPTH-entry shift register of {valid, reg}.
  - Shifts on every adv cycle; entry 0 is loaded with {accept & memread, rd}.
  - Oldest entry drops off.
  - flush clears all entries.
- FSM states RUN, HALT, EXC:
  - RUN->HALT on accept of opcode 00000. The HALT word itself is emitted with out_valid. halted=1 from the next cycle. in_ready=0 until reset; flush is ignored in HALT.
  - RUN->EXC on accept of SIIC (00010). A counter loads EXC_CYCLES and decrements each cycle. EXC->RUN when it reaches 0. exc_busy=1 in EXC.
  - flush in EXC returns to RUN next cycle.
  - RTI (00011) is an ordinary instruction in RUN.
- Flush:
  - Next cycle out_valid=0 and scoreboard cleared.
  - Same-cycle in_valid is not accepted.
  - Flush overrides out_ready completion of the held entry (entry dropped).
- Simultaneous hazard and flush: flush wins; no stall next cycle because the scoreboard is empty.
- Reset mid-EXC or mid-stall: immediate return to reset values.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs perf_issued[15:0] (accepts) and perf_stall[15:0] (cycles with in_valid & hazard & state==RUN). Both are saturating, reset to 0, and cleared on rst_n only.
- Undefined: no ports, no logic.

Decomposition:
- ctrl_pkg holds:
  - opcode/func localparams and ALU op encodings (ROL 000, SLL 001, ROR 010, SRL 011, ADD 100, OR 101, XOR 110, AND 111);
  - CTRL_W bit-position constants;
  - FSM state encoding;
  - decode function returning {ctrl, use_rs, use_rt, rd_sel}.
- One sub-module: ctrl_load_scoreboard (shift register plus match compare).

Test Plan:
- LD r1 (0x8A20) then ADD r2,r1,r3 (0xD968), HAZ_DEPTH=1, out_ready=1 -> ADD accepted exactly one cycle late, one out_valid=0 bubble between them.
- ADDI r1,r2,5 (0x4225) with out_ready=0 for 3 cycles -> ctrl/idx stable, in_ready=0, word delivered on first out_ready=1. ctrl has aluop=100, alusrc=1, regwrite=1.
- SIIC (0x1000) with EXC_CYCLES=3 -> exc_busy=1 for 3 cycles, in_ready=0, next instruction accepted on cycle 4.
- HALT (0x0000) -> HALT word emitted, halted=1 next cycle. in_ready stays 0 for 20 cycles despite flush; rst_n low clears halted.
- LD r1 accepted, flush asserted while dependent ADD waits -> scoreboard empty, ADD accepted the cycle after flush with no bubble.
- CTRL_PERF_CNT_EN defined: stall scenario of test 1 -> perf_issued=2, perf_stall=1.
